// File: rtl/sram_rw_ctrl_if.sv
// Request/response and wordline bundle shared by the requester, sram_rw_ctrl and the SRAM macro.
// The controller takes the slave view; the requester/testbench takes the master view.
interface sram_rw_ctrl_if #(
  parameter int ROWS  = 4,
  parameter int WIDTH = 1,
  parameter int AW    = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0] data_drv;
  logic [ROWS-1:0]  row_wr;
  logic [ROWS-1:0]  row_rd;
  logic [WIDTH-1:0] sa_out;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sa_out,
    output req_ready, data_drv, row_wr, row_rd, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sa_out,
    input  req_ready, data_drv, row_wr, row_rd, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_rw_ctrl.sv
// Read/write sequencer for the SRAM macro: accepts one word request at a time and emits
// fixed-length registered one-hot row_wr/row_rd pulses followed by an all-low recovery gap.
module sram_rw_ctrl #(
  parameter int ROWS  = 4,
  parameter int WIDTH = 1,
  parameter int AW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int T_WR  = 10,
  parameter int T_RD  = 10,
  parameter int T_GAP = 10
) (
  input logic           clk,
  input logic           rst_n,
  sram_rw_ctrl_if.slave bus
);

  localparam int TPULSE = (T_WR > T_RD) ? T_WR : T_RD;
  localparam int TMAX   = (TPULSE > T_GAP) ? TPULSE : T_GAP;
  localparam int CW     = $clog2(TMAX + 1);

  if (T_WR < 1 || T_RD < 1 || T_GAP < 1 || ROWS < 2 || AW < 1) begin : g_param_err
    $error("sram_rw_ctrl: illegal parameters (T_WR/T_RD/T_GAP must be >= 1, ROWS >= 2)");
  end

  typedef enum logic [1:0] {
    IDLE,
    WR_PULSE,
    RD_PULSE,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             oor_q, oor_d;
  logic [WIDTH-1:0] data_drv_q, data_drv_d;
  logic [ROWS-1:0]  row_wr_q, row_wr_d;
  logic [ROWS-1:0]  row_rd_q, row_rd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic accept;
  logic pulse_done;

  assign accept     = bus.req_valid && (state_q == IDLE);
  assign pulse_done = ((state_q == WR_PULSE) || (state_q == RD_PULSE)) && (cnt_q == '0);

  // The counter is reloaded on every state entry, so each phase simply runs down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = bus.req_we ? WR_PULSE : RD_PULSE;
          cnt_d   = bus.req_we ? CW'(T_WR - 1) : CW'(T_RD - 1);
          addr_d  = bus.req_addr;
          oor_d   = (int'(bus.req_addr) >= ROWS);
        end
      end
      WR_PULSE, RD_PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CW'(T_GAP - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rows are decoded from the next state so the flops drive them directly, glitch-free.
  always_comb begin
    row_wr_d = '0;
    row_rd_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (int'(addr_d) == i) begin
        row_wr_d[i] = (state_d == WR_PULSE);
        row_rd_d[i] = (state_d == RD_PULSE);
      end
    end
    data_drv_d  = (accept && bus.req_we) ? bus.req_wdata : data_drv_q;
    rsp_valid_d = pulse_done;
    rsp_err_d   = pulse_done && oor_q;
    rsp_rdata_d = (pulse_done && (state_q == RD_PULSE) && !oor_q) ? bus.sa_out : rsp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      oor_q       <= 1'b0;
      data_drv_q  <= '0;
      row_wr_q    <= '0;
      row_rd_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      oor_q       <= oor_d;
      data_drv_q  <= data_drv_d;
      row_wr_q    <= row_wr_d;
      row_rd_q    <= row_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.data_drv  = data_drv_q;
  assign bus.row_wr    = row_wr_q;
  assign bus.row_rd    = row_rd_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  a_rows_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(row_wr_q | row_rd_q));
  a_rsp_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid_q |=> !rsp_valid_q);
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    bus.req_ready == (state_q == IDLE));
  a_err_qualified: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_err_q |-> rsp_valid_q);

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Bench for sram_rw_ctrl: a cycle-indexed model of accepted operations checked every cycle,
// plus directed literal checks, and a ROWS=3 instance for out-of-range addressing.
module tb_sram_rw_ctrl;

  localparam int ROWS  = 4;
  localparam int T_WR  = 10;
  localparam int T_RD  = 10;
  localparam int T_GAP = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  sram_rw_ctrl_if #(.ROWS(4), .WIDTH(1), .AW(2)) bus4 ();
  sram_rw_ctrl_if #(.ROWS(3), .WIDTH(1), .AW(2)) bus3 ();

  sram_rw_ctrl #(.ROWS(4), .WIDTH(1), .AW(2), .T_WR(T_WR), .T_RD(T_RD), .T_GAP(T_GAP)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  sram_rw_ctrl #(.ROWS(3), .WIDTH(1), .AW(2), .T_WR(T_WR), .T_RD(T_RD), .T_GAP(T_GAP)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: the single operation in flight, described by its accept cycle.
  bit        opValid = 1'b0;
  int        opK = 0;
  bit        opWe = 1'b0;
  int        opAddr = 0;
  int        opT = 0;
  int        nextFree = 0;
  logic      dataModel = 1'b0;
  logic      rdataModel = 1'b0;
  logic [3:0] expWr, expRd;
  logic      expValid, expErr, expReady;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Outputs in cycle c follow from the op accepted at k: pulse k+1..k+T, strobe k+T+1, ready at k+T+T_GAP+1.
  always @(negedge clk) begin : compare
    if (!rst_n) begin
      opValid    = 1'b0;
      nextFree   = cyc;
      dataModel  = 1'b0;
      rdataModel = 1'b0;
    end
    expWr = '0;
    expRd = '0;
    if (opValid && cyc > opK && cyc <= opK + opT && opAddr < ROWS) begin
      if (opWe) expWr = 4'(1 << opAddr);
      else      expRd = 4'(1 << opAddr);
    end
    expValid = opValid && (cyc == opK + opT + 1);
    expErr   = expValid && (opAddr >= ROWS);
    expReady = (cyc >= nextFree);
    checkOutput("row_wr", 32'(bus4.row_wr), 32'(expWr));
    checkOutput("row_rd", 32'(bus4.row_rd), 32'(expRd));
    checkOutput("req_ready", 32'(bus4.req_ready), 32'(expReady));
    checkOutput("rsp_valid", 32'(bus4.rsp_valid), 32'(expValid));
    checkOutput("rsp_err", 32'(bus4.rsp_err), 32'(expErr));
    checkOutput("rsp_rdata", 32'(bus4.rsp_rdata), 32'(rdataModel));
    checkOutput("data_drv", 32'(bus4.data_drv), 32'(dataModel));
    if (rst_n) begin
      if (opValid && !opWe && opAddr < ROWS && cyc == opK + opT) rdataModel = bus4.sa_out;
      if (bus4.req_valid && cyc >= nextFree) begin
        opValid  = 1'b1;
        opK      = cyc;
        opWe     = bus4.req_we;
        opAddr   = int'(bus4.req_addr);
        opT      = opWe ? T_WR : T_RD;
        nextFree = cyc + opT + T_GAP + 1;
        if (opWe) dataModel = bus4.req_wdata;
      end
    end
  end

  task automatic gotoCycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic setSa(input bit sel, input logic v);
    @(posedge clk);
    #1;
    if (sel) bus3.sa_out = v;
    else     bus4.sa_out = v;
  endtask

  // Presents a request and waits (bounded) for the handshake; acc returns the accept cycle.
  task automatic applyStimulus(input bit sel, input bit we, input int addr, input logic wdata,
                               input bit hold, output int acc);
    acc = -1;
    @(posedge clk);
    #1;
    if (sel) begin
      bus3.req_we = we; bus3.req_addr = 2'(addr); bus3.req_wdata = wdata; bus3.req_valid = 1'b1;
    end else begin
      bus4.req_we = we; bus4.req_addr = 2'(addr); bus4.req_wdata = wdata; bus4.req_valid = 1'b1;
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rst_n && (sel ? bus3.req_ready : bus4.req_ready)) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout cyc=%0d got=no_accept exp=accept", cyc);
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (sel) bus3.req_valid = 1'b0;
      else     bus4.req_valid = 1'b0;
    end
  endtask

  task automatic readWithLast(input int addr, input logic last);
    int k;
    applyStimulus(1'b0, 1'b0, addr, 1'b0, 1'b0, k);
    gotoCycle(k + 9);
    setSa(1'b0, last);
    setSa(1'b0, 1'b0);
    gotoCycle(k + 11);
    checkOutput("t3 rdata_last_sample", 32'(bus4.rsp_rdata), 32'(last));
    gotoCycle(k + 21);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int k, a0, a1, a2;
    bus4.req_valid = 1'b0; bus4.req_we = 1'b0; bus4.req_addr = '0; bus4.req_wdata = '0; bus4.sa_out = '0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0; bus3.sa_out = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset ready", 32'(bus4.req_ready), 32'd1);
    checkOutput("reset rows", 32'({bus4.row_wr, bus4.row_rd}), 32'd0);
    checkOutput("reset rsp", 32'({bus4.rsp_valid, bus4.rsp_err, bus4.rsp_rdata, bus4.data_drv}), 32'd0);
    #2 rst_n = 1'b1;

    // Write 1 to row 2.
    applyStimulus(1'b0, 1'b1, 2, 1'b1, 1'b0, k);
    gotoCycle(k + 1);
    checkOutput("t1 row_wr first", 32'(bus4.row_wr), 32'b0100);
    checkOutput("t1 data_drv", 32'(bus4.data_drv), 32'd1);
    gotoCycle(k + 10);
    checkOutput("t1 row_wr last", 32'(bus4.row_wr), 32'b0100);
    gotoCycle(k + 11);
    checkOutput("t1 row_wr off", 32'(bus4.row_wr), 32'd0);
    checkOutput("t1 rsp_valid", 32'(bus4.rsp_valid), 32'd1);
    checkOutput("t1 rsp_err", 32'(bus4.rsp_err), 32'd0);
    gotoCycle(k + 20);
    checkOutput("t1 ready busy", 32'(bus4.req_ready), 32'd0);
    gotoCycle(k + 21);
    checkOutput("t1 ready back", 32'(bus4.req_ready), 32'd1);

    // Read row 2 with sa_out high throughout.
    setSa(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2, 1'b0, 1'b0, k);
    gotoCycle(k + 10);
    checkOutput("t2 row_rd last", 32'(bus4.row_rd), 32'b0100);
    checkOutput("t2 row_wr idle", 32'(bus4.row_wr), 32'd0);
    gotoCycle(k + 11);
    checkOutput("t2 rsp_valid", 32'(bus4.rsp_valid), 32'd1);
    checkOutput("t2 rsp_rdata", 32'(bus4.rsp_rdata), 32'd1);
    gotoCycle(k + 21);
    setSa(1'b0, 1'b0);

    // Write 0, then reads where only the final row_rd cycle carries the answer.
    applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0, k);
    gotoCycle(k + 21);
    readWithLast(2, 1'b0);
    readWithLast(2, 1'b1);
    readWithLast(1, 1'b0);

    // Three back-to-back requests with req_valid never dropped.
    applyStimulus(1'b0, 1'b1, 0, 1'b1, 1'b1, a0);
    applyStimulus(1'b0, 1'b0, 3, 1'b0, 1'b1, a1);
    applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0, a2);
    checkOutput("t4 spacing 0-1", 32'(a1 - a0), 32'd21);
    checkOutput("t4 spacing 1-2", 32'(a2 - a1), 32'd21);
    gotoCycle(a2 + 21);

    // ROWS=3 instance: a good read first so the out-of-range read has a value to preserve.
    bus3.sa_out = 1'b1;
    applyStimulus(1'b1, 1'b0, 1, 1'b0, 1'b0, k);
    gotoCycle(k + 10);
    checkOutput("t5 good row_rd", 32'(bus3.row_rd), 32'b010);
    gotoCycle(k + 11);
    checkOutput("t5 good rdata", 32'(bus3.rsp_rdata), 32'd1);
    checkOutput("t5 good err", 32'(bus3.rsp_err), 32'd0);
    gotoCycle(k + 21);
    bus3.sa_out = 1'b0;
    applyStimulus(1'b1, 1'b0, 3, 1'b0, 1'b0, k);
    for (int c = k + 1; c <= k + 10; c++) begin
      gotoCycle(c);
      checkOutput("t5 oor no rows", 32'({bus3.row_wr, bus3.row_rd}), 32'd0);
    end
    gotoCycle(k + 11);
    checkOutput("t5 oor rsp_valid", 32'(bus3.rsp_valid), 32'd1);
    checkOutput("t5 oor rsp_err", 32'(bus3.rsp_err), 32'd1);
    checkOutput("t5 oor rdata kept", 32'(bus3.rsp_rdata), 32'd1);
    gotoCycle(k + 20);
    checkOutput("t5 oor ready busy", 32'(bus3.req_ready), 32'd0);
    gotoCycle(k + 21);
    applyStimulus(1'b1, 1'b1, 3, 1'b1, 1'b0, k);
    gotoCycle(k + 1);
    checkOutput("t5 oor wr data_drv", 32'(bus3.data_drv), 32'd1);
    checkOutput("t5 oor wr no rows", 32'({bus3.row_wr, bus3.row_rd}), 32'd0);
    gotoCycle(k + 11);
    checkOutput("t5 oor wr err", 32'({bus3.rsp_valid, bus3.rsp_err}), 32'b11);
    gotoCycle(k + 21);

    // Reset in the middle of a write pulse.
    applyStimulus(1'b0, 1'b1, 1, 1'b1, 1'b0, k);
    gotoCycle(k + 5);
    checkOutput("t6 row_wr mid", 32'(bus4.row_wr), 32'b0010);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6 async row_wr", 32'(bus4.row_wr), 32'd0);
    checkOutput("t6 async ready", 32'(bus4.req_ready), 32'd1);
    checkOutput("t6 async data_drv", 32'(bus4.data_drv), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    gotoCycle(cyc + 1);
    checkOutput("t6 ready after", 32'(bus4.req_ready), 32'd1);
    setSa(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1, 1'b0, 1'b0, k);
    gotoCycle(k + 10);
    checkOutput("t6 read row_rd", 32'(bus4.row_rd), 32'b0010);
    gotoCycle(k + 11);
    checkOutput("t6 read rdata", 32'(bus4.rsp_rdata), 32'd1);
    gotoCycle(k + 22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
